// File: rtl/run_ranker_pkg.sv
// run_ranker_pkg
// Shared definitions for the run ranker: time word width, table depth,
// the insertion FSM state encoding, read-select codes and table-mode codes.
package run_ranker_pkg;

    // Packed digits, most-significant first, so unsigned compare is time order
    localparam int TIME_W = 39;
    localparam int DEPTH  = 3;

    typedef enum logic [2:0] {
        IDLE,
        CMP0,
        CMP1,
        CMP2,
        WRITE
    } state_t;

    localparam logic [2:0] SEL_UP0 = 3'd0;
    localparam logic [2:0] SEL_UP1 = 3'd1;
    localparam logic [2:0] SEL_UP2 = 3'd2;
    localparam logic [2:0] SEL_DN0 = 3'd3;
    localparam logic [2:0] SEL_DN1 = 3'd4;
    localparam logic [2:0] SEL_DN2 = 3'd5;

    localparam logic [1:0] LB_NONE = 2'b00;
    localparam logic [1:0] LB_UP   = 2'b01;
    localparam logic [1:0] LB_DOWN = 2'b10;

endpackage

// File: rtl/run_ranker_table.sv
// rank_table
// One three-slot ranked table. Slot 0 is best. The table answers "does the
// new time belong at slot cmp_idx" and performs the shift/insert on write.
// Ports:
//   clock, reset      clock and async active-high reset
//   clear             synchronous wipe of all slots
//   new_time          candidate time word
//   cmp_idx           slot currently being compared against
//   place_here        slot cmp_idx is empty or the candidate beats it
//   write_en          insert new_time at write_pos, shifting worse slots down
//   write_pos         insertion slot
//   slot_time         stored time words
//   slot_valid        slot occupancy
module rank_table #(
    parameter int TIME_W     = 39,
    parameter int DEPTH      = 3,
    parameter bit descending = 1'b0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          clear,
    input  logic [TIME_W-1:0]             new_time,
    input  logic [1:0]                    cmp_idx,
    output logic                          place_here,
    input  logic                          write_en,
    input  logic [1:0]                    write_pos,
    output logic [DEPTH-1:0][TIME_W-1:0]  slot_time,
    output logic [DEPTH-1:0]              slot_valid
);

    logic [TIME_W-1:0] cmp_time;
    logic              cmp_valid;

    // Pick the slot under comparison, then apply the better rule. Ties are not
    // "better", so an equal new time keeps scanning and lands below the old one.
    always_comb begin
        cmp_time  = slot_time[0];
        cmp_valid = slot_valid[0];
        case (cmp_idx)
            2'd1: begin
                cmp_time  = slot_time[1];
                cmp_valid = slot_valid[1];
            end
            2'd2: begin
                cmp_time  = slot_time[2];
                cmp_valid = slot_valid[2];
            end
            default: ;
        endcase
        if (!cmp_valid) begin
            place_here = 1'b1;
        end else if (descending) begin
            place_here = (new_time > cmp_time);
        end else begin
            place_here = (new_time < cmp_time);
        end
    end

    // Insert at write_pos; every slot below it takes its upper neighbour and
    // the old slot 2 falls off the end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            slot_time  <= '0;
            slot_valid <= '0;
        end else if (clear) begin
            slot_time  <= '0;
            slot_valid <= '0;
        end else if (write_en) begin
            if (write_pos == 2'd0) begin
                slot_time[0]  <= new_time;
                slot_valid[0] <= 1'b1;
                slot_time[1]  <= slot_time[0];
                slot_valid[1] <= slot_valid[0];
                slot_time[2]  <= slot_time[1];
                slot_valid[2] <= slot_valid[1];
            end else if (write_pos == 2'd1) begin
                slot_time[1]  <= new_time;
                slot_valid[1] <= 1'b1;
                slot_time[2]  <= slot_time[1];
                slot_valid[2] <= slot_valid[1];
            end else begin
                slot_time[2]  <= new_time;
                slot_valid[2] <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/run_ranker.sv
// run_ranker
// Captures finished stopwatch run times and ranks them into a count-up table
// (smaller is better) and a count-down table (larger is better).
// Ports:
//   clock, reset   clock and async active-high reset
//   clear          synchronous wipe of tables, rank, lb_mode and dropped
//   time_in        finished run time, valid with time_valid
//   time_valid     one-cycle pulse
//   run_down       0 = count-up run, 1 = count-down run
//   rd_sel         0-2 up[0..2], 3-5 down[0..2], 6-7 nothing
//   rd_time        selected entry (0 when empty)
//   rd_valid       selected entry occupied
//   busy           insertion in progress
//   dropped        sticky: a run arrived while busy
//   rank           one-hot place of the last run, 000 = no place
//   lb_mode        table of the last run
//   place_pulse    one-cycle pulse on the place taken
module run_ranker #(
    parameter int TIME_W = run_ranker_pkg::TIME_W,
    parameter int DEPTH  = run_ranker_pkg::DEPTH
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic [TIME_W-1:0] time_in,
    input  logic              time_valid,
    input  logic              run_down,
    input  logic [2:0]        rd_sel,
    output logic [TIME_W-1:0] rd_time,
    output logic              rd_valid,
    output logic              busy,
    output logic              dropped,
    output logic [2:0]        rank,
    output logic [1:0]        lb_mode,
    output logic [2:0]        place_pulse
);

    import run_ranker_pkg::*;

    state_t state_q, state_d;

    logic [TIME_W-1:0] new_time_q;
    logic              new_down_q;
    logic [1:0]        pos_q;
    logic [1:0]        cmp_idx;
    logic              write_up, write_dn;
    logic              up_place, dn_place, win;

    logic [DEPTH-1:0][TIME_W-1:0] up_time, dn_time;
    logic [DEPTH-1:0]             up_valid, dn_valid;

    rank_table #(.TIME_W(TIME_W), .DEPTH(DEPTH), .descending(1'b0)) up_table (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .new_time   (new_time_q),
        .cmp_idx    (cmp_idx),
        .place_here (up_place),
        .write_en   (write_up),
        .write_pos  (pos_q),
        .slot_time  (up_time),
        .slot_valid (up_valid)
    );

    rank_table #(.TIME_W(TIME_W), .DEPTH(DEPTH), .descending(1'b1)) dn_table (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .new_time   (new_time_q),
        .cmp_idx    (cmp_idx),
        .place_here (dn_place),
        .write_en   (write_dn),
        .write_pos  (pos_q),
        .slot_time  (dn_time),
        .slot_valid (dn_valid)
    );

    assign win = new_down_q ? dn_place : up_place;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: scan slots best-first; clear always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (time_valid) state_d = CMP0;
            CMP0:    state_d = win ? WRITE : CMP1;
            CMP1:    state_d = win ? WRITE : CMP2;
            CMP2:    state_d = win ? WRITE : IDLE;
            WRITE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear) begin
            state_d = IDLE;
        end
    end

    // FSM outputs; a clear during WRITE suppresses the table write
    always_comb begin
        busy     = (state_q != IDLE);
        cmp_idx  = 2'd0;
        write_up = 1'b0;
        write_dn = 1'b0;
        case (state_q)
            CMP1:    cmp_idx = 2'd1;
            CMP2:    cmp_idx = 2'd2;
            WRITE: begin
                write_up = !new_down_q && !clear;
                write_dn =  new_down_q && !clear;
            end
            default: ;
        endcase
    end

    // Latched run, winning slot and the registered rank/mode/pulse outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            new_time_q  <= '0;
            new_down_q  <= 1'b0;
            pos_q       <= 2'd0;
            rank        <= 3'b000;
            lb_mode     <= LB_NONE;
            place_pulse <= 3'b000;
            dropped     <= 1'b0;
        end else begin
            place_pulse <= 3'b000;
            if (clear) begin
                rank    <= 3'b000;
                lb_mode <= LB_NONE;
                dropped <= 1'b0;
            end else begin
                if (time_valid && busy) begin
                    dropped <= 1'b1;
                end
                case (state_q)
                    IDLE: begin
                        if (time_valid) begin
                            new_time_q <= time_in;
                            new_down_q <= run_down;
                        end
                    end
                    CMP0, CMP1, CMP2: begin
                        if (win) begin
                            pos_q <= cmp_idx;
                        end else if (state_q == CMP2) begin
                            rank    <= 3'b000;
                            lb_mode <= new_down_q ? LB_DOWN : LB_UP;
                        end
                    end
                    WRITE: begin
                        rank        <= 3'b001 << pos_q;
                        lb_mode     <= new_down_q ? LB_DOWN : LB_UP;
                        place_pulse <= 3'b001 << pos_q;
                    end
                    default: ;
                endcase
            end
        end
    end

    logic [TIME_W-1:0] pick_time;
    logic              pick_valid;

    // Read port; empty slots and unused codes read as zero/invalid
    always_comb begin
        pick_time  = '0;
        pick_valid = 1'b0;
        case (rd_sel)
            SEL_UP0: begin pick_time = up_time[0]; pick_valid = up_valid[0]; end
            SEL_UP1: begin pick_time = up_time[1]; pick_valid = up_valid[1]; end
            SEL_UP2: begin pick_time = up_time[2]; pick_valid = up_valid[2]; end
            SEL_DN0: begin pick_time = dn_time[0]; pick_valid = dn_valid[0]; end
            SEL_DN1: begin pick_time = dn_time[1]; pick_valid = dn_valid[1]; end
            SEL_DN2: begin pick_time = dn_time[2]; pick_valid = dn_valid[2]; end
            default: ;
        endcase
        rd_valid = pick_valid;
        rd_time  = pick_valid ? pick_time : '0;
    end

endmodule

// File: tb/tb_run_ranker.sv
module tb_run_ranker;

    import run_ranker_pkg::*;

    logic              clock = 1'b0;
    logic              reset;
    logic              clear;
    logic [38:0]       time_in;
    logic              time_valid;
    logic              run_down;
    logic [2:0]        rd_sel;
    logic [38:0]       rd_time;
    logic              rd_valid;
    logic              busy;
    logic              dropped;
    logic [2:0]        rank;
    logic [1:0]        lb_mode;
    logic [2:0]        place_pulse;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [2:0] rank;
        logic [1:0] lb;
        int         cyc;
    } exp_t;

    typedef struct {
        logic        down;
        logic [38:0] t;
        logic [2:0]  rank;
        logic [1:0]  lb;
        int          cyc;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[7];

    run_ranker dut (
        .clock       (clock),
        .reset       (reset),
        .clear       (clear),
        .time_in     (time_in),
        .time_valid  (time_valid),
        .run_down    (run_down),
        .rd_sel      (rd_sel),
        .rd_time     (rd_time),
        .rd_valid    (rd_valid),
        .busy        (busy),
        .dropped     (dropped),
        .rank        (rank),
        .lb_mode     (lb_mode),
        .place_pulse (place_pulse)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkSlot(input logic [2:0] sel, input logic [38:0] exp_time, input logic exp_valid);
        rd_sel = sel;
        #1;
        checkOutput($sformatf("rd_time sel=%0d", sel), 64'(rd_time), 64'(exp_time));
        checkOutput($sformatf("rd_valid sel=%0d", sel), 64'(rd_valid), 64'(exp_valid));
    endtask

    // Drive one run, push its expectation, follow it until busy drops
    task automatic applyStimulus(input logic down, input logic [38:0] t,
                                 input logic [2:0] exp_rank, input logic [1:0] exp_lb,
                                 input int exp_cyc);
        exp_t e;
        exp_t got_e;
        logic [2:0] got_pulse;
        int got_cyc;
        bit done;
        e.rank = exp_rank;
        e.lb   = exp_lb;
        e.cyc  = exp_cyc;
        sb.push_back(e);
        time_in    = t;
        run_down   = down;
        time_valid = 1'b1;
        got_pulse  = 3'b000;
        got_cyc    = -1;
        done       = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            time_valid = 1'b0;
            if (c == 1) begin
                checkOutput($sformatf("busy c1 t=%0d", t), 64'(busy), 64'd1);
            end
            if (place_pulse != 3'b000 && got_cyc < 0) begin
                got_pulse = place_pulse;
                got_cyc   = c;
            end
            if (!busy) begin
                done = 1'b1;
                break;
            end
        end
        checkOutput($sformatf("finish t=%0d", t), 64'(done), 64'd1);
        got_e = sb.pop_front();
        checkOutput($sformatf("rank t=%0d", t), 64'(rank), 64'(got_e.rank));
        checkOutput($sformatf("lb_mode t=%0d", t), 64'(lb_mode), 64'(got_e.lb));
        checkOutput($sformatf("pulse t=%0d", t), 64'(got_pulse), 64'(got_e.rank));
        checkOutput($sformatf("pulse_cyc t=%0d", t), 64'(got_cyc), 64'(got_e.cyc));
    endtask

    initial begin
        logic [2:0] pulse_or;

        vecs[0] = '{1'b0, 39'd500, 3'b001, LB_UP,   3};
        vecs[1] = '{1'b0, 39'd300, 3'b001, LB_UP,   3};
        vecs[2] = '{1'b0, 39'd400, 3'b010, LB_UP,   4};
        vecs[3] = '{1'b0, 39'd600, 3'b000, LB_UP,  -1};
        vecs[4] = '{1'b1, 39'd200, 3'b001, LB_DOWN, 3};
        vecs[5] = '{1'b1, 39'd900, 3'b001, LB_DOWN, 3};
        vecs[6] = '{1'b1, 39'd900, 3'b010, LB_DOWN, 4};

        reset      = 1'b1;
        clear      = 1'b0;
        time_in    = '0;
        time_valid = 1'b0;
        run_down   = 1'b0;
        rd_sel     = 3'd0;
        repeat (2) tick();
        reset = 1'b0;
        tick();

        // Reset state
        for (int s = 0; s < 8; s++) begin
            checkSlot(3'(s), 39'd0, 1'b0);
        end
        checkOutput("reset rank", 64'(rank), 64'd0);
        checkOutput("reset busy", 64'(busy), 64'd0);
        checkOutput("reset dropped", 64'(dropped), 64'd0);
        checkOutput("reset lb_mode", 64'(lb_mode), 64'd0);
        checkOutput("reset pulse", 64'(place_pulse), 64'd0);

        // Table-driven runs
        for (int i = 0; i < 7; i++) begin
            applyStimulus(vecs[i].down, vecs[i].t, vecs[i].rank, vecs[i].lb, vecs[i].cyc);
        end
        checkSlot(SEL_UP0, 39'd300, 1'b1);
        checkSlot(SEL_UP1, 39'd400, 1'b1);
        checkSlot(SEL_UP2, 39'd500, 1'b1);
        checkSlot(SEL_DN0, 39'd900, 1'b1);
        checkSlot(SEL_DN1, 39'd900, 1'b1);
        checkSlot(SEL_DN2, 39'd200, 1'b1);
        checkSlot(3'd6, 39'd0, 1'b0);
        checkSlot(3'd7, 39'd0, 1'b0);

        // Wipe, then a second time_valid at cycle 2 of an insertion
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkSlot(SEL_UP0, 39'd0, 1'b0);
        checkSlot(SEL_DN0, 39'd0, 1'b0);
        checkOutput("clear rank", 64'(rank), 64'd0);
        time_in = 39'd700; run_down = 1'b0; time_valid = 1'b1;
        tick();
        time_valid = 1'b0;
        tick();
        time_in = 39'd50; time_valid = 1'b1;
        tick();
        time_valid = 1'b0;
        checkOutput("dropped set", 64'(dropped), 64'd1);
        checkOutput("busy after drop", 64'(busy), 64'd0);
        tick();
        checkSlot(SEL_UP0, 39'd700, 1'b1);
        checkSlot(SEL_UP1, 39'd0, 1'b0);
        checkOutput("dropped sticky", 64'(dropped), 64'd1);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("dropped cleared", 64'(dropped), 64'd0);

        // Clear during CMP1 with a full up table
        applyStimulus(1'b0, 39'd300, 3'b001, LB_UP, 3);
        applyStimulus(1'b0, 39'd400, 3'b010, LB_UP, 4);
        applyStimulus(1'b0, 39'd500, 3'b100, LB_UP, 5);
        time_in = 39'd450; run_down = 1'b0; time_valid = 1'b1;
        tick();
        time_valid = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checkOutput("clear abort busy", 64'(busy), 64'd0);
        pulse_or = place_pulse;
        repeat (3) begin
            tick();
            pulse_or = pulse_or | place_pulse;
        end
        checkOutput("clear abort pulse", 64'(pulse_or), 64'd0);
        checkOutput("clear abort rank", 64'(rank), 64'd0);
        for (int s = 0; s < 6; s++) begin
            checkSlot(3'(s), 39'd0, 1'b0);
        end

        // Clear and time_valid together
        clear = 1'b1; time_valid = 1'b1; time_in = 39'd42; run_down = 1'b1;
        tick();
        clear = 1'b0; time_valid = 1'b0;
        checkOutput("clear+valid busy", 64'(busy), 64'd0);
        repeat (4) tick();
        checkSlot(SEL_DN0, 39'd0, 1'b0);
        checkSlot(SEL_UP0, 39'd0, 1'b0);

        // Async reset during WRITE
        applyStimulus(1'b0, 39'd250, 3'b001, LB_UP, 3);
        time_in = 39'd150; run_down = 1'b0; time_valid = 1'b1;
        tick();
        time_valid = 1'b0;
        tick();
        checkOutput("pre-reset busy", 64'(busy), 64'd1);
        #1;
        reset = 1'b1;
        #2;
        checkOutput("async rank", 64'(rank), 64'd0);
        checkOutput("async busy", 64'(busy), 64'd0);
        checkOutput("async lb_mode", 64'(lb_mode), 64'd0);
        checkSlot(SEL_UP0, 39'd0, 1'b0);
        tick();
        checkOutput("reset pulse hold", 64'(place_pulse), 64'd0);
        reset = 1'b0;
        tick();
        checkOutput("post reset pulse", 64'(place_pulse), 64'd0);
        applyStimulus(1'b0, 39'd100, 3'b001, LB_UP, 3);
        checkSlot(SEL_UP0, 39'd100, 1'b1);
        checkSlot(SEL_UP1, 39'd0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/run_ranker.md
# run_ranker

Consumer end of the stopwatch time interface. It captures each finished run time that `stopwatch` presents at stop. It keeps two ranked 3-entry tables: count-up runs, where smaller is better, and count-down runs, where larger remaining time is better. Stored entries are read back through a select port for the display path. It drives the rank LEDs, the table-mode LEDs and the per-place sound pulses for `music`.

## Interface
- `TIME_W`, 39: width of a time word; packed digits, most-significant first, so unsigned compare equals time order.
- `DEPTH`, 3: entries per table; fixed at 3 for this revision.
- `clock`  in  1: system clock; all state on rising edge.
- `reset`  in  1: asynchronous, active-high; clears everything.
- `clear`  in  1: synchronous table wipe.
- `time_in`  in  TIME_W: finished run time.
- `time_valid`  in  1: one-cycle pulse, `time_in` valid.
- `run_down`  in  1: 0 = count-up run, 1 = count-down run; sampled with `time_valid`.
- `rd_sel`  in  3: read select.
- `rd_time`  out  TIME_W: selected entry, combinational from registers.
- `rd_valid`  out  1: selected entry occupied.
- `busy`  out  1: insertion in progress.
- `dropped`  out  1: sticky; a `time_valid` arrived while busy.
- `rank`  out  3: one-hot place of the last run; 000 = no place.
- `lb_mode`  out  2: table of the last run; 01 = up, 10 = down.
- `place_pulse`  out  3: one-cycle pulse, bit k = run took place k+1.

## Operation
- Tables: up[0..2] and down[0..2]. Each slot holds a time word and a valid bit. Index 0 is best.
- Better rule:
  - Up table: new < slot.
  - Down table: new > slot.
  - An empty slot is worse than any time.
  - Ties: the new entry ranks below the existing equal entry.
- States: IDLE, CMP0, CMP1, CMP2, WRITE.
- IDLE: on `time_valid`, latch `time_in` and `run_down`, then go to CMP0.
- CMPk: if slot k is empty or new is better, set pos = k and go to WRITE.
- Else, in CMP0/CMP1, go to CMP(k+1).
- Else, in CMP2, set `rank` = 000, set `lb_mode` from the latched table, and go to IDLE. The run is not stored.
- WRITE:
  - Move slots pos..1 down one place; the old slot 2 is discarded.
  - Write the new entry at pos with valid = 1.
  - Set `rank` = one-hot(pos) and `lb_mode` from the latched table.
  - Pulse `place_pulse[pos]`, then go to IDLE.
- `busy` = 1 in every state except IDLE.
- `time_valid` while busy is ignored and sets `dropped`. Only `reset` or `clear` clear `dropped`.
- `clear` in any state:
  - Empties both tables and sets `rank` = 000, `lb_mode` = 00, `dropped` = 0.
  - Aborts any insertion without a pulse and returns to IDLE.
  - `clear` and `time_valid` in the same cycle: `clear` wins and the time is discarded.
- `rd_sel` decode:
  - 0–2 select up[0..2].
  - 3–5 select down[0..2].
  - 6–7 give `rd_time` = 0 and `rd_valid` = 0.
  - An empty slot reads `rd_time` = 0 and `rd_valid` = 0.

## Timing
- Reset values: state IDLE, all slots empty, `rd_time` 0, `rd_valid` 0, `busy` 0, `dropped` 0, `rank` 000, `lb_mode` 00, `place_pulse` 000.
- Cycle 0 is `time_valid` high in IDLE. Cycle 1 is CMP0, and `busy` is high from cycle 1.
- A win at slot k puts WRITE at cycle k+2. `place_pulse` is high during cycle k+3, which is the cycle after the WRITE edge.
- The table update and `rank` become visible at cycle k+3.
- Non-placing run: `rank` = 000 at cycle 4.
- A new `time_valid` is accepted in the first cycle `busy` is low again. Worst-case spacing is 5 cycles.
- `reset` asserted mid-insertion: immediate return to reset values, no pulse.

## Structure
- `run_ranker_pkg` holds:
  - the state enum (IDLE, CMP0, CMP1, CMP2, WRITE);
  - `TIME_W`, `DEPTH`;
  - the `rd_sel` codes (`SEL_UP0`..`SEL_DN2`);
  - the `lb_mode` codes (`LB_NONE`, `LB_UP`, `LB_DOWN`).
- One sub-module is natural: `rank_table`, one 3-slot shift/insert table with a `descending` parameter for the better rule. It is instantiated twice. The FSM stays in `run_ranker`.

## Test plan
- Reset, then read all `rd_sel` values: every read returns 0/invalid, `rank` = 000, `busy` = 0.
- Up runs 500, 300, 400, 600:
  - up table = 300, 400, 500.
  - The fourth run gives `rank` = 000 and no pulse.
  - The second run gives `place_pulse` = 001 at cycle 3.
- Down runs 200, 900, then a tie at 900:
  - down table = 900, 900, 200.
  - The tie gives `rank` = 010 and `lb_mode` = 10.
- `time_valid` pulsed at cycle 2 of an insertion: the second time is absent from the table and `dropped` = 1. `clear` then clears it.
- `clear` asserted during CMP1 with a full up table: tables empty, no pulse, IDLE next cycle. `clear` plus `time_valid` together: nothing is stored.
- Async `reset` during WRITE: outputs return to reset values without waiting for a clock edge, and a following run of 100 lands in up[0].
